// File: rtl/multiplex_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : multiplex_display_driver
// Brief    : Multiplexed 7-segment driver with tear-free double buffering,
//            PWM dimming, per-digit blink and one-cycle anti-ghost dead time.
// Revision : 1.0 - initial release
// ============================================================================
module multiplex_display_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_PERIOD = 100000,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic [PWM_BITS-1:0]     brightness_in,
  input  logic                    load_in,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done_out
);

  localparam int c_DW = (COUNT_PERIOD > 0) ? $clog2(COUNT_PERIOD + 1) : 1;
  localparam int c_IW = $clog2(NUM_DIGITS);
  localparam int c_FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [c_DW-1:0]       c_DWELL_MAX = c_DW'(COUNT_PERIOD);
  localparam logic [c_IW-1:0]       c_IDX_MAX   = c_IW'(NUM_DIGITS - 1);
  localparam logic [c_FW-1:0]       c_FRAME_MAX = c_FW'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] c_AN_ONE    = NUM_DIGITS'(1);

  // Scan state
  logic [c_DW-1:0]       r_dwell;
  logic [c_IW-1:0]       r_idx;
  logic [c_FW-1:0]       r_frame;
  logic                  r_blink_phase;
  logic [PWM_BITS-1:0]   r_pwm;

  // Pending (host-facing) and active (display-facing) register sets
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic [NUM_DIGITS-1:0]   r_pend_blink;
  logic [PWM_BITS-1:0]     r_pend_bright;
  logic                    r_pend_valid;

  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;
  logic [NUM_DIGITS-1:0]   r_act_blink;
  logic [PWM_BITS-1:0]     r_act_bright;

  // Registered pins
  logic [6:0]            r_cat;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_done;

  logic                  w_dwell_end;
  logic                  w_wrap;
  logic [3:0]            w_nibble;
  logic                  w_dp_sel;
  logic                  w_blank_sel;
  logic                  w_blink_sel;
  logic [6:0]            w_seg;
  logic                  w_pwm_on;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_an_sel;

  assign w_dwell_end = (r_dwell == c_DWELL_MAX);
  assign w_wrap      = w_dwell_end && (r_idx == c_IDX_MAX);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_dwell       <= '0;
      r_idx         <= '0;
      r_frame       <= '0;
      r_blink_phase <= 1'b0;
      r_pwm         <= '0;
    end else begin
      r_pwm <= r_pwm + PWM_BITS'(1);
      if (w_dwell_end) begin
        r_dwell <= '0;
        r_idx   <= (r_idx == c_IDX_MAX) ? '0 : r_idx + c_IW'(1);
      end else begin
        r_dwell <= r_dwell + c_DW'(1);
      end
      if (w_wrap) begin
        if (r_frame == c_FRAME_MAX) begin
          r_frame       <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame <= r_frame + c_FW'(1);
        end
      end
    end
  end

  // A load on the wrap cycle stays pending; the wrap commits what was already there.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pend_val    <= '0;
      r_pend_dp     <= '0;
      r_pend_blank  <= '0;
      r_pend_blink  <= '0;
      r_pend_bright <= '0;
      r_pend_valid  <= 1'b0;
      r_act_val     <= '0;
      r_act_dp      <= '0;
      r_act_blank   <= '1;
      r_act_blink   <= '0;
      r_act_bright  <= '0;
    end else begin
      if (load_in) begin
        r_pend_val    <= val_in;
        r_pend_dp     <= dp_in;
        r_pend_blank  <= blank_in;
        r_pend_blink  <= blink_in;
        r_pend_bright <= brightness_in;
        r_pend_valid  <= 1'b1;
      end else if (w_wrap) begin
        r_pend_valid  <= 1'b0;
      end
      if (w_wrap && r_pend_valid) begin
        r_act_val    <= r_pend_val;
        r_act_dp     <= r_pend_dp;
        r_act_blank  <= r_pend_blank;
        r_act_blink  <= r_pend_blink;
        r_act_bright <= r_pend_bright;
      end
    end
  end

  always_comb begin
    w_nibble    = '0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b1;
    w_blink_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == c_IW'(i)) begin
        w_nibble    = r_act_val[4*i +: 4];
        w_dp_sel    = r_act_dp[i];
        w_blank_sel = r_act_blank[i];
        w_blink_sel = r_act_blink[i];
      end
    end
  end

  // Active-high glyphs, bit0 = a ... bit6 = g
  always_comb begin
    w_seg = 7'h00;
    case (w_nibble)
      4'h0:    w_seg = 7'h3F;
      4'h1:    w_seg = 7'h06;
      4'h2:    w_seg = 7'h5B;
      4'h3:    w_seg = 7'h4F;
      4'h4:    w_seg = 7'h66;
      4'h5:    w_seg = 7'h6D;
      4'h6:    w_seg = 7'h7D;
      4'h7:    w_seg = 7'h07;
      4'h8:    w_seg = 7'h7F;
      4'h9:    w_seg = 7'h6F;
      4'hA:    w_seg = 7'h77;
      4'hB:    w_seg = 7'h7C;
      4'hC:    w_seg = 7'h39;
      4'hD:    w_seg = 7'h5E;
      4'hE:    w_seg = 7'h79;
      default: w_seg = 7'h71;
    endcase
  end

  // All-ones brightness is forced fully on so full scale really means 100%.
  assign w_pwm_on = (&r_act_bright) || (r_pwm < r_act_bright);
  assign w_lit    = ~w_blank_sel && ~(w_blink_sel && r_blink_phase)
                    && w_pwm_on && (r_dwell != '0);
  assign w_an_sel = ~(c_AN_ONE << r_idx);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_an         <= '1;
      r_cat        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_lit) begin
        r_an  <= w_an_sel;
        r_cat <= ~w_seg;
        r_dp  <= ~w_dp_sel;
      end else begin
        r_an  <= '1;
        r_cat <= 7'h7F;
        r_dp  <= 1'b1;
      end
    end
  end

  assign an_out         = r_an;
  assign cat_out        = r_cat;
  assign dp_out         = r_dp;
  assign frame_done_out = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_multiplex_display_driver.sv
`default_nettype none
// Bench for multiplex_display_driver: per-cycle scoreboard derived from scan
// arithmetic and a load log, plus literal expectations for the scan pattern.
module tb_multiplex_display_driver;

  localparam int N  = 4;
  localparam int P  = 3;
  localparam int PB = 2;
  localparam int BF = 2;
  localparam int DW = P + 1;
  localparam int FL = N * DW;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          load_in = 1'b0;
  logic [15:0]   val_in = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blank_in = '0;
  logic [3:0]    blink_in = '0;
  logic [PB-1:0] brightness_in = '0;
  logic [6:0]    cat_out;
  logic          dp_out;
  logic [3:0]    an_out;
  logic          frame_done_out;

  multiplex_display_driver #(
    .NUM_DIGITS(N), .COUNT_PERIOD(P), .PWM_BITS(PB), .BLINK_FRAMES(BF)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .val_in(val_in), .dp_in(dp_in),
    .blank_in(blank_in), .blink_in(blink_in), .brightness_in(brightness_in),
    .load_in(load_in), .cat_out(cat_out), .dp_out(dp_out), .an_out(an_out),
    .frame_done_out(frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  int st = 0;    // clock edges since reset release
  bit chk_en = 1'b1;

  always @(posedge clk_in or posedge rst_in)
    if (rst_in) st <= 0;
    else        st <= st + 1;

  typedef struct {
    int          c;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic [1:0]  br;
  } ld_t;
  ld_t ld_q[$];

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pins after the edge that leaves state j.
  function automatic void model(input int j, output logic [3:0] an, output logic [6:0] cat,
                                output logic d, output logic fd);
    int dw, idx, pwm, f, ph;
    logic lit;
    logic [3:0] one;
    ld_t a;
    a = '{c: 0, val: 16'h0, dp: 4'h0, blank: 4'hF, blink: 4'h0, br: 2'd0};
    dw  = j % DW;
    idx = (j / DW) % N;
    pwm = j % (1 << PB);
    f   = j / FL;
    ph  = (f / BF) % 2;
    foreach (ld_q[k]) if (ld_q[k].c <= f * FL - 2) a = ld_q[k];
    lit = !a.blank[idx] && !(a.blink[idx] && ph == 1)
          && (a.br == 2'd3 || pwm < int'(a.br)) && dw != 0;
    one = 4'b0001;
    an  = lit ? ~(one << idx) : 4'hF;
    cat = lit ? ~seg_tab[a.val[idx*4 +: 4]] : 7'h7F;
    d   = lit ? ~a.dp[idx] : 1'b1;
    fd  = (j % FL) == FL - 1;
  endfunction

  logic [3:0] e_an;
  logic [6:0] e_cat;
  logic       e_dp, e_fd;

  always @(negedge clk_in) begin
    if (chk_en) begin
      if (rst_in || st == 0) begin
        e_an = 4'hF; e_cat = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      end else begin
        model(st - 1, e_an, e_cat, e_dp, e_fd);
      end
      check("an_out", an_out, e_an);
      check("cat_out", cat_out, e_cat);
      check("dp_out", dp_out, e_dp);
      check("frame_done_out", frame_done_out, e_fd);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] bl,
                         input logic [3:0] bk, input logic [1:0] br);
    ld_t e;
    val_in = v; dp_in = d; blank_in = bl; blink_in = bk; brightness_in = br;
    load_in = 1'b1;
    e = '{c: st, val: v, dp: d, blank: bl, blink: bk, br: br};
    ld_q.push_back(e);
    @(negedge clk_in);
    load_in = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] v, input string name);
    int n = 0;
    while (an_out !== v && n < 4 * FL) begin
      @(negedge clk_in);
      n++;
    end
    if (an_out !== v) check(name, an_out, v);
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (frame_done_out !== 1'b1 && n < 4 * FL);
    if (frame_done_out !== 1'b1) check(name, frame_done_out, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cnt2;
    tick(3);
    check("reset_an", an_out, 4'hF);
    check("reset_cat", cat_out, 7'h7F);
    rst_in = 1'b0;
    tick(4);

    // Scan pattern
    do_load(16'h3210, 4'h0, 4'h0, 4'h0, 2'd3);
    wait_an(4'b1110, "wait_dig0"); check("scan_cat0", cat_out, 7'h40);
    wait_an(4'b1101, "wait_dig1"); check("scan_cat1", cat_out, 7'h79);
    wait_an(4'b1011, "wait_dig2"); check("scan_cat2", cat_out, 7'h24);
    wait_an(4'b0111, "wait_dig3"); check("scan_cat3", cat_out, 7'h30);
    wait_fd("wait_fd_a");
    cnt = 0;
    do begin @(negedge clk_in); cnt++; end while (frame_done_out !== 1'b1 && cnt < 40);
    check("frame_period", cnt, 16);

    // Tear-free mid-frame load
    tick(5);
    do_load(16'hFFFF, 4'h0, 4'h0, 4'h0, 2'd3);
    cnt = 0; cnt2 = 0;
    while (frame_done_out !== 1'b1 && cnt2 < 40) begin
      @(negedge clk_in); cnt2++;
      if (cat_out == 7'h0E) cnt++;
    end
    check("tear_old_frame_0E", cnt, 0);
    cnt = 0; cnt2 = 0;
    repeat (FL) begin
      @(negedge clk_in);
      if (an_out != 4'hF) cnt++;
      if (cat_out == 7'h0E) cnt2++;
    end
    check("tear_new_lit", cnt, 12);
    check("tear_new_0E", cnt2, 12);

    // Load on the frame-boundary cycle
    tick(15);
    do_load(16'h8421, 4'h0, 4'h0, 4'h0, 2'd3);
    cnt = 0;
    repeat (FL) begin @(negedge clk_in); if (cat_out == 7'h0E) cnt++; end
    check("bound_frame_still_F", cnt, 12);
    cnt = 0;
    repeat (FL) begin @(negedge clk_in); if (an_out == 4'b1110 && cat_out == 7'h79) cnt++; end
    check("bound_next_frame_dig0", cnt, 3);

    // PWM
    do_load(16'h3210, 4'h0, 4'h0, 4'h0, 2'd1);
    tick(2 * FL);
    cnt = 0;
    repeat (FL) begin @(negedge clk_in); if (an_out != 4'hF) cnt++; end
    check("pwm1_lit", cnt, 0);
    do_load(16'h3210, 4'h0, 4'h0, 4'h0, 2'd2);
    tick(2 * FL);
    cnt = 0;
    repeat (FL) begin @(negedge clk_in); if (an_out != 4'hF) cnt++; end
    check("pwm2_lit", cnt, 4);
    do_load(16'h3210, 4'h0, 4'h0, 4'h0, 2'd0);
    tick(2 * FL);
    cnt = 0;
    repeat (FL) begin @(negedge clk_in); if (an_out != 4'hF) cnt++; end
    check("pwm0_lit", cnt, 0);

    // Blink and decimal point
    do_load(16'h3210, 4'b0001, 4'h0, 4'b0010, 2'd3);
    tick(2 * FL);
    cnt = 0; cnt2 = 0;
    repeat (2 * BF * FL) begin
      @(negedge clk_in);
      if (an_out == 4'b1101) cnt++;
      if (dp_out == 1'b0) cnt2++;
    end
    check("blink_dig1_lit", cnt, 6);
    check("dp_low_count", cnt2, 12);
    cnt = 0;
    repeat (FL) begin @(negedge clk_in); if (dp_out == 1'b0 && an_out != 4'b1110) cnt++; end
    check("dp_only_dig0", cnt, 0);

    // Asynchronous reset mid-scan
    wait_an(4'b1110, "wait_pre_reset");
    #2;
    rst_in = 1'b1;
    ld_q.delete();
    #1;
    check("async_rst_an", an_out, 4'hF);
    check("async_rst_cat", cat_out, 7'h7F);
    check("async_rst_dp", dp_out, 1);
    check("async_rst_fd", frame_done_out, 0);
    tick(2);
    rst_in = 1'b0;
    cnt = 0;
    repeat (2 * FL) begin @(negedge clk_in); if (an_out != 4'hF) cnt++; end
    check("post_rst_dark", cnt, 0);
    do_load(16'h3210, 4'h0, 4'h0, 4'h0, 2'd3);
    tick(2 * FL);
    cnt = 0;
    repeat (FL) begin @(negedge clk_in); if (an_out != 4'hF) cnt++; end
    check("post_rst_relit", cnt, 12);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
